alu_vector_checker: RTL and testbench

- Sequential stimulus-and-response partner for the 8-operation signed ALU. It drives every (x, y, op) combination into the ALU, samples the ALU result, and compares it against an internal golden model.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the ALU on the lab board/testbench as its driver and checker. It does not replace the ALU.

---
 rtl/alu_vector_checker_pkg.sv | 37 +++
 rtl/alu_vector_checker_golden.sv | 14 +
 rtl/alu_vector_checker.sv | 118 +++++++++++
 tb/tb_alu_vector_checker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_vector_checker_pkg.sv
// alu_vector_checker_pkg: op codes, FSM state codes and the golden ALU function shared by the checker and its benches
package alu_vector_checker_pkg;
  localparam logic [2:0] OP_AVG  = 3'd0;
  localparam logic [2:0] OP_ADD2 = 3'd1;
  localparam logic [2:0] OP_HADD = 3'd2;
  localparam logic [2:0] OP_HSUB = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_APPLY = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
  // x and y arrive sign-extended to 32 bits; the result is masked to n+3 bits
  function automatic logic [31:0] golden(input int n, input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] s);
    logic signed [31:0] sx, sy;
    logic [31:0] lm, rm, r;
    sx = x;
    sy = y;
    lm = (32'd1 << (n + 1)) - 32'd1;
    rm = (32'd1 << (n + 3)) - 32'd1;
    case (s)
      OP_AVG:  r = (sx + sy) >>> 1;
      OP_ADD2: r = (sx + sy) <<< 1;
      OP_HADD: r = (sx >>> 1) + sy;
      OP_HSUB: r = sx - (sy >>> 1);
      OP_NAND: r = ~(x & y) & lm;
      OP_NOT:  r = ~x & lm;
      OP_NOR:  r = ~(x | y) & lm;
      default: r = (x ^ y) & lm;
    endcase
    return r & rm;
  endfunction
endpackage

// File: rtl/alu_vector_checker_golden.sv
// alu_golden_model: combinational expected ALU result for one (x, y, s) vector
module alu_golden_model
  import alu_vector_checker_pkg::*;
#(
  parameter int n = 3
) (
  input  logic [n:0]   x,
  input  logic [n:0]   y,
  input  logic [2:0]   s,
  output logic [n+2:0] exp_o
);
  localparam int RW = n + 3;
  always_comb exp_o = RW'(golden(n, 32'($signed(x)), 32'($signed(y)), s));
endmodule

// File: rtl/alu_vector_checker.sv
// alu_vector_checker: sweeps every (s, x, y) vector into an ALU and checks o_i against the golden model.
// Build option ALU_CHK_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module alu_vector_checker
  import alu_vector_checker_pkg::*;
#(
  parameter int n     = 3,
  parameter int LAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [n:0]       x_o,
  output logic [n:0]       y_o,
  output logic [2:0]       s_o,
  input  logic [n+2:0]     o_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [n:0]       fail_x,
  output logic [n:0]       fail_y,
  output logic [2:0]       fail_s,
  output logic [n+2:0]     fail_o
);
  localparam int W  = n + 1;
  localparam int VW = 3 + 2 * W;
  localparam int LW = LAT > 0 ? $clog2(LAT + 1) : 1;
  state_t st_q, st_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic armed_q, armed_d;
  logic [n:0] fx_q, fx_d, fy_q, fy_d;
  logic [2:0] fs_q, fs_d;
  logic [n+2:0] fo_q, fo_d, exp_v;
  logic mis, last, go, stop;
  // one concatenated counter gives s outermost, then x, then y
  assign s_o = vec_q[VW-1 -: 3];
  assign x_o = vec_q[2*W-1 -: W];
  assign y_o = vec_q[W-1:0];
  alu_golden_model #(.n(n)) u_gold (.x(x_o), .y(y_o), .s(s_o), .exp_o(exp_v));
  assign mis  = (st_q == ST_CHECK) && (o_i != exp_v);
  assign last = &vec_q;
  assign go   = start && (st_q == ST_IDLE || st_q == ST_DONE);
`ifdef ALU_CHK_STOP_ON_ERR_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    st_d = st_q;
    vec_d = vec_q;
    lat_d = lat_q;
    err_d = err_q;
    armed_d = armed_q;
    fx_d = fx_q;
    fy_d = fy_q;
    fs_d = fs_q;
    fo_d = fo_q;
    if (go) begin
      st_d = ST_APPLY;
      vec_d = '0;
      lat_d = '0;
      err_d = '0;
      armed_d = 1'b1;
      fx_d = '0;
      fy_d = '0;
      fs_d = '0;
      fo_d = '0;
    end else if (st_q == ST_APPLY) begin
      st_d = (lat_q == LW'(LAT)) ? ST_CHECK : ST_APPLY;
      lat_d = (lat_q == LW'(LAT)) ? '0 : lat_q + 1'b1;
    end else if (st_q == ST_CHECK) begin
      if (mis) begin
        err_d = &err_q ? err_q : err_q + 1'b1;
        armed_d = 1'b0;
        fx_d = armed_q ? x_o : fx_q;
        fy_d = armed_q ? y_o : fy_q;
        fs_d = armed_q ? s_o : fs_q;
        fo_d = armed_q ? o_i : fo_q;
      end
      st_d = (last || stop) ? ST_DONE : ST_APPLY;
      vec_d = (last || stop) ? vec_q : vec_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;
      vec_q <= '0;
      lat_q <= '0;
      err_q <= '0;
      armed_q <= 1'b1;
      fx_q <= '0;
      fy_q <= '0;
      fs_q <= '0;
      fo_q <= '0;
    end else begin
      st_q <= st_d;
      vec_q <= vec_d;
      lat_q <= lat_d;
      err_q <= err_d;
      armed_q <= armed_d;
      fx_q <= fx_d;
      fy_q <= fy_d;
      fs_q <= fs_d;
      fo_q <= fo_d;
    end
  end
  assign busy      = (st_q == ST_APPLY) || (st_q == ST_CHECK);
  assign done      = (st_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_x    = fx_q;
  assign fail_y    = fy_q;
  assign fail_s    = fs_q;
  assign fail_o    = fo_q;
endmodule

// File: tb/tb_alu_vector_checker.sv
// tb_alu_vector_checker: drives the checker with a modelled ALU (optionally faulty) and checks it against a sweep model
module tb_alu_vector_checker;
  localparam int N = 3;
  localparam int W = N + 1;
  localparam int RW = N + 3;
  localparam int LASTV = 8 * (1 << (2 * W)) - 1;
  logic clk = 0, rst = 1, start = 0;
  always #5 clk = ~clk;
  logic [N:0] x_o, y_o, fail_x, fail_y;
  logic [2:0] s_o, fail_s;
  logic [RW-1:0] o_i, fail_o;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [N:0] sx_o, sy_o, sfx, sfy;
  logic [2:0] ss_o, sfs;
  logic [RW-1:0] sfo;
  logic s_busy, s_done, s_pass;
  logic [3:0] s_err;
  logic [N:0] gx, gy;
  logic [2:0] gs;
  logic [RW-1:0] gexp;
  int total = 0, bad = 0;
  bit fault = 0;
  alu_vector_checker dut (.clk(clk), .rst(rst), .start(start), .x_o(x_o), .y_o(y_o), .s_o(s_o),
    .o_i(o_i), .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_x(fail_x),
    .fail_y(fail_y), .fail_s(fail_s), .fail_o(fail_o));
  alu_vector_checker #(.CNT_W(4)) sat (.clk(clk), .rst(rst), .start(start), .x_o(sx_o), .y_o(sy_o),
    .s_o(ss_o), .o_i('0), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .fail_x(sfx), .fail_y(sfy), .fail_s(sfs), .fail_o(sfo));
  alu_golden_model #(.n(N)) gm (.x(gx), .y(gy), .s(gs), .exp_o(gexp));
  function automatic int ref_alu(int x, int y, int s);
    int m = (1 << W) - 1;
    case (s)
      0: return (x + y) >>> 1;
      1: return (x + y) * 2;
      2: return (x >>> 1) + y;
      3: return x - (y >>> 1);
      4: return ~(x & y) & m;
      5: return ~x & m;
      6: return ~(x | y) & m;
      default: return (x ^ y) & m;
    endcase
  endfunction
  function automatic int vs(int v);
    return v >= (1 << N) ? v - (1 << W) : v;
  endfunction
  always_comb o_i = RW'(ref_alu(vs(int'(x_o)), vs(int'(y_o)), int'(s_o))) ^ RW'(fault && s_o == 3'd7);
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  bit track = 0, m_done = 0, m_armed = 1;
  int cyc, m_err, m_fx, m_fy, m_fs, m_fo;
  always @(negedge clk) begin : mdl
    int k, ex, ey, es, r;
    if (track) begin
      if (!m_done) begin
        k = cyc / 2;
        es = k >> (2 * W);
        ex = (k >> W) & ((1 << W) - 1);
        ey = k & ((1 << W) - 1);
        check("busy", busy, 1);
        check("vector", {s_o, x_o, y_o}, (es << (2 * W)) | (ex << W) | ey);
        if (cyc % 2 == 1) begin
          r = ref_alu(vs(ex), vs(ey), es) & ((1 << RW) - 1);
          if (int'(o_i) != r) begin
            if (m_err < 65535) m_err++;
            if (m_armed) begin
              m_armed = 0;
              m_fx = ex;
              m_fy = ey;
              m_fs = es;
              m_fo = int'(o_i);
            end
`ifdef ALU_CHK_STOP_ON_ERR_EN
            m_done = 1;
`endif
          end
          if (k == LASTV) m_done = 1;
        end
        cyc++;
      end else begin
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("err_count", err_count, m_err);
        check("pass", pass, m_err == 0);
        check("fail_x", fail_x, m_fx);
        check("fail_y", fail_y, m_fy);
        check("fail_s", fail_s, m_fs);
        check("fail_o", fail_o, m_fo);
        track = 0;
      end
    end
  end
  task automatic sweep(input bit f, input int poke, output int n);
    fault = f;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 0; m_done = 0; m_err = 0; m_armed = 1;
    m_fx = 0; m_fy = 0; m_fs = 0; m_fo = 0;
    track = 1;
    n = 0;
    while (!done && n < 6000) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke);
    end
    start = 0;
    check("done_timeout", done, 1);
    @(posedge clk); #1;
  endtask
  task automatic check_reset();
    check("rst_x", x_o, 0); check("rst_y", y_o, 0); check("rst_s", s_o, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_pass", pass, 0);
    check("rst_err", err_count, 0); check("rst_fx", fail_x, 0); check("rst_fy", fail_y, 0);
    check("rst_fs", fail_s, 0); check("rst_fo", fail_o, 0); check("rst_sat_busy", s_busy, 0);
  endtask
  int tx[8] = '{5, 5, 5, 5, 5, 5, -8, -8};
  int ty[8] = '{3, 3, 3, 3, 3, 3, -8, 7};
  int ts[8] = '{0, 1, 2, 3, 4, 5, 1, 3};
  int te[8] = '{4, 16, 5, 4, 14, 10, -32, -11};
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      gx = W'(tx[i]); gy = W'(ty[i]); gs = 3'(ts[i]);
      #1;
      check("gold_lit", int'($signed(gexp)), te[i]);
      check("ref_lit", ref_alu(tx[i], ty[i], ts[i]), te[i]);
    end
    for (int v = 0; v < 2048; v += 7) begin
      {gs, gx, gy} = 11'(v);
      #1 check("gold_sweep", int'($signed(gexp)), ref_alu(vs(int'(gx)), vs(int'(gy)), int'(gs)));
    end
    sweep(0, 0, n);
    check("sweep_cycles", n, 4096);
    check("pass_golden", pass, 1);
    check("err_golden", err_count, 0);
    check("sat_done", s_done, 1);
    check("sat_pass", s_pass, 0);
`ifdef ALU_CHK_STOP_ON_ERR_EN
    check("sat_err", s_err, 1);
`else
    check("sat_err", s_err, 15);
`endif
    sweep(1, 0, n);
    check("fault_pass", pass, 0);
    check("fault_fs", fail_s, 7);
    check("fault_fx", fail_x, 0);
    check("fault_fy", fail_y, 0);
    check("fault_fo", fail_o, 1);
`ifdef ALU_CHK_STOP_ON_ERR_EN
    check("fault_err", err_count, 1);
    check("fault_cycles", n, 2 * (7 * 256 + 1));
`else
    check("fault_err", err_count, 256);
    check("fault_cycles", n, 4096);
`endif
    fault = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (100) @(posedge clk);
    #1 rst = 1;
    #1 check_reset();
    @(posedge clk); #1 rst = 0;
    sweep(0, 50, n);
    check("restart_cycles", n, 4096);
    check("restart_pass", pass, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
